csr_ctrl: RTL and testbench

Initiator side of the CSR register-file access interface. Accepts decoded Zicsr instructions, trap-entry and MRET requests from the pipeline and sequences them into single-port read/write cycles on the `csr_reg_rdpin`/`csr_reg_wrpin` bus. It returns old CSR values to the register-writeback path and produces PC redirects for trap entry and return. It sits between the execute stage and the machine-mode CSR file.

---
 rtl/csr_ctrl_pkg.sv | 62 ++++++
 rtl/csr_ctrl_if.sv | 45 ++++
 rtl/csr_wdata_gen.sv | 43 ++++
 rtl/csr_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_csr_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl_pkg: shared types and constants for the CSR access initiator.
// FSM state encoding, Zicsr funct3 codes, machine CSR addresses,
// mstatus field positions and the mstatus update helpers for trap entry and MRET.
package csr_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        IDLE,
        C_RD,
        C_WR,
        C_RSP,
        T_EPC,
        T_CAUSE,
        T_SRD,
        T_SWR,
        T_VRD,
        M_SRD,
        M_SWR,
        M_ERD,
        REDIR
    } state_t;

    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RS  = 3'b010;
    localparam logic [2:0] OP_RC  = 3'b011;
    localparam logic [2:0] OP_RWI = 3'b101;
    localparam logic [2:0] OP_RSI = 3'b110;
    localparam logic [2:0] OP_RCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous privilege.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] n;
        n = s;
        n[MSTATUS_MPIE] = s[MSTATUS_MIE];
        n[MSTATUS_MIE]  = 1'b0;
        n[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return n;
    endfunction

    // MRET: restore MIE from MPIE and set MPIE.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] n;
        n = s;
        n[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        n[MSTATUS_MPIE] = 1'b1;
        return n;
    endfunction

endpackage

// File: rtl/csr_ctrl_if.sv
// csr_ctrl_if: pipeline request/response, trap/MRET events and CSR-file bus.
// slave modport is the controller; master modport is the pipeline plus CSR file.
interface csr_ctrl_if;
    import csr_ctrl_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_rs1;
    logic [4:0]      req_zimm;
    logic            req_rd_zero;
    logic            req_src_zero;
    logic            trap_req;
    logic            mret_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            evt_ack;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
    logic            csr_reg_rdpin;
    logic            csr_reg_wrpin;
    logic [XLEN-1:0] csr_addr32;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_pc;
    logic [XLEN-1:0] csr_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_rs1, req_zimm, req_rd_zero, req_src_zero,
        input  trap_req, mret_req, trap_cause, trap_pc, csr_rdata,
        output req_ready, evt_ack, rsp_valid, rsp_rdata, redirect_valid, redirect_pc, busy,
        output csr_reg_rdpin, csr_reg_wrpin, csr_addr32, csr_wdata, csr_pc
    );

    modport master (
        output req_valid, req_op, req_addr, req_rs1, req_zimm, req_rd_zero, req_src_zero,
        output trap_req, mret_req, trap_cause, trap_pc, csr_rdata,
        input  req_ready, evt_ack, rsp_valid, rsp_rdata, redirect_valid, redirect_pc, busy,
        input  csr_reg_rdpin, csr_reg_wrpin, csr_addr32, csr_wdata, csr_pc
    );

endinterface

// File: rtl/csr_wdata_gen.sv
// csr_wdata_gen: Zicsr write-data and write-enable for RW/RS/RC and immediate forms.
// RS/RC with a zero source must not write; funct3 000/100 never write.
module csr_wdata_gen
    import csr_ctrl_pkg::*;
(
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [4:0]      i_zimm,
    input  logic            i_src_zero,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_we
);

    logic [XLEN-1:0] w_src;

    assign w_src = i_op[2] ? {27'b0, i_zimm} : i_rs1;

    // Select write data from the low funct3 bits; the immediate bit only picks the source.
    always_comb begin
        o_wdata = '0;
        o_we    = 1'b0;
        case (i_op[1:0])
            OP_RW[1:0]: begin
                o_wdata = w_src;
                o_we    = 1'b1;
            end
            OP_RS[1:0]: begin
                o_wdata = i_old | w_src;
                o_we    = ~i_src_zero;
            end
            OP_RC[1:0]: begin
                o_wdata = i_old & ~w_src;
                o_we    = ~i_src_zero;
            end
            default: begin
                o_wdata = '0;
                o_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl: sequences Zicsr instructions, trap entry and MRET into single-port
// CSR read/write cycles. Bus strobes, address and write data are registered.
// Build option: CSR_VECTORED_EN enables vectored mtvec for interrupt causes.
module csr_ctrl
    import csr_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    csr_ctrl_if.slave bus
);

    state_t          r_state;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_rs1;
    logic [4:0]      r_zimm;
    logic            r_src_zero;
    logic [XLEN-1:0] r_old;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic            r_rdpin;
    logic            r_wrpin;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_redir_valid;
    logic [XLEN-1:0] r_redir_pc;

    logic            w_idle;
    logic            w_rd_supp;
    logic [XLEN-1:0] w_old_next;
    logic [XLEN-1:0] w_gen_wdata;
    logic            w_gen_we;
    logic [XLEN-1:0] w_vec_pc;

    assign w_idle        = (r_state == IDLE);
    assign bus.req_ready = w_idle & ~bus.trap_req & ~bus.mret_req;
    assign bus.evt_ack   = rst & w_idle & (bus.trap_req | bus.mret_req);
    assign bus.busy      = ~w_idle;

    assign bus.csr_reg_rdpin  = r_rdpin;
    assign bus.csr_reg_wrpin  = r_wrpin;
    assign bus.csr_addr32     = {20'b0, r_addr};
    assign bus.csr_wdata      = r_wdata;
    assign bus.csr_pc         = r_pc;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.redirect_valid = r_redir_valid;
    assign bus.redirect_pc    = r_redir_pc;

    // RW/RWI to x0 skip the read; reserved funct3 codes touch nothing.
    assign w_rd_supp  = (bus.req_op[1:0] == 2'b00) |
                        ((bus.req_op[1:0] == OP_RW[1:0]) & bus.req_rd_zero);
    assign w_old_next = r_rdpin ? bus.csr_rdata : '0;

    csr_wdata_gen u_wdata_gen (
        .i_op       (r_op),
        .i_old      (w_old_next),
        .i_rs1      (r_rs1),
        .i_zimm     (r_zimm),
        .i_src_zero (r_src_zero),
        .o_wdata    (w_gen_wdata),
        .o_we       (w_gen_we)
    );

    // Trap target from the mtvec value on the read bus during T_VRD.
    always_comb begin
        w_vec_pc = {bus.csr_rdata[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_EN
        if ((bus.csr_rdata[1:0] == 2'b01) && r_cause[XLEN-1])
            w_vec_pc = {bus.csr_rdata[XLEN-1:2], 2'b00} + {r_cause[XLEN-3:0], 2'b00};
`endif
    end

    // Main sequencer: state plus every registered bus and response output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_op          <= '0;
            r_rs1         <= '0;
            r_zimm        <= '0;
            r_src_zero    <= 1'b0;
            r_old         <= '0;
            r_cause       <= '0;
            r_pc          <= '0;
            r_rdpin       <= 1'b0;
            r_wrpin       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.trap_req) begin
                        r_state <= T_EPC;
                        r_pc    <= bus.trap_pc;
                        r_cause <= bus.trap_cause;
                        r_wrpin <= 1'b1;
                        r_addr  <= CSR_MEPC;
                        r_wdata <= bus.trap_pc;
                    end else if (bus.mret_req) begin
                        r_state <= M_SRD;
                        r_rdpin <= 1'b1;
                        r_addr  <= CSR_MSTATUS;
                    end else if (bus.req_valid) begin
                        r_state    <= C_RD;
                        r_op       <= bus.req_op;
                        r_rs1      <= bus.req_rs1;
                        r_zimm     <= bus.req_zimm;
                        r_src_zero <= bus.req_src_zero;
                        r_rdpin    <= ~w_rd_supp;
                        r_addr     <= bus.req_addr;
                    end
                end
                C_RD: begin
                    r_state <= C_WR;
                    r_old   <= w_old_next;
                    r_rdpin <= 1'b0;
                    r_wrpin <= w_gen_we;
                    r_wdata <= w_gen_wdata;
                end
                C_WR: begin
                    r_state     <= C_RSP;
                    r_wrpin     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_old;
                end
                C_RSP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
                T_EPC: begin
                    r_state <= T_CAUSE;
                    r_addr  <= CSR_MCAUSE;
                    r_wdata <= r_cause;
                end
                T_CAUSE: begin
                    r_state <= T_SRD;
                    r_wrpin <= 1'b0;
                    r_rdpin <= 1'b1;
                    r_addr  <= CSR_MSTATUS;
                end
                T_SRD: begin
                    r_state <= T_SWR;
                    r_rdpin <= 1'b0;
                    r_wrpin <= 1'b1;
                    r_wdata <= trap_mstatus(bus.csr_rdata);
                end
                T_SWR: begin
                    r_state <= T_VRD;
                    r_wrpin <= 1'b0;
                    r_rdpin <= 1'b1;
                    r_addr  <= CSR_MTVEC;
                end
                T_VRD: begin
                    r_state       <= REDIR;
                    r_rdpin       <= 1'b0;
                    r_redir_valid <= 1'b1;
                    r_redir_pc    <= w_vec_pc;
                end
                M_SRD: begin
                    r_state <= M_SWR;
                    r_rdpin <= 1'b0;
                    r_wrpin <= 1'b1;
                    r_wdata <= mret_mstatus(bus.csr_rdata);
                end
                M_SWR: begin
                    r_state <= M_ERD;
                    r_wrpin <= 1'b0;
                    r_rdpin <= 1'b1;
                    r_addr  <= CSR_MEPC;
                end
                M_ERD: begin
                    r_state       <= REDIR;
                    r_rdpin       <= 1'b0;
                    r_redir_valid <= 1'b1;
                    r_redir_pc    <= bus.csr_rdata & ~32'h3;
                end
                REDIR: begin
                    r_state       <= IDLE;
                    r_redir_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_rdpin <= 1'b0;
                    r_wrpin <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: directed bench for csr_ctrl with a behavioural CSR file.
// Table of Zicsr vectors plus hand sequences for trap, MRET, pending events and reset.
module tb_csr_ctrl;
    import csr_ctrl_pkg::*;

    logic clk;
    logic rst;
    csr_ctrl_if bus ();

    csr_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Behavioural CSR file: six implemented registers, zero elsewhere.
    logic [31:0] mem [0:7];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_val;

    function automatic int cidx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h304: return 1;
            12'h305: return 2;
            12'h341: return 3;
            12'h342: return 4;
            12'h344: return 5;
            default: return 7;
        endcase
    endfunction

    function automatic logic [31:0] csr_val(input logic [11:0] a);
        if (cidx(a) == 7) return 32'h0;
        return mem[cidx(a)];
    endfunction

    always_comb begin
        bus.csr_rdata = 32'h0;
        if (cidx(bus.csr_addr32[11:0]) != 7) bus.csr_rdata = mem[cidx(bus.csr_addr32[11:0])];
    end

    always @(posedge clk) begin
        if (pl_en) mem[cidx(pl_addr)] <= pl_val;
        else if (bus.csr_reg_wrpin) mem[cidx(bus.csr_addr32[11:0])] <= bus.csr_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_val = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Watch an event sequence from cycle 1: first redirect cycle/pc, strobe clashes, stray responses.
    task automatic watch_redirect(output int cyc, output logic [31:0] pc, output int clash, output int rsps);
        cyc = 0; pc = 32'h0; clash = 0; rsps = 0;
        for (int c = 1; c <= 10; c++) begin
            if (bus.redirect_valid && cyc == 0) begin cyc = c; pc = bus.redirect_pc; end
            if (bus.csr_reg_rdpin && bus.csr_reg_wrpin) clash++;
            if (bus.rsp_valid) rsps++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        rd_zero;
        logic        src_zero;
        logic [31:0] init;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rsp;
        logic [31:0] exp_final;
    } vec_t;

    vec_t vt [12];

    int          cyc, clash, rsps;
    logic [31:0] rpc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        clk = 1'b0; rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_val = '0;
        bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_rs1 = 0; bus.req_zimm = 0;
        bus.req_rd_zero = 0; bus.req_src_zero = 0; bus.trap_req = 0; bus.mret_req = 0;
        bus.trap_cause = 0; bus.trap_pc = 0;

        //            op      addr     rs1          zimm  rdz  srcz init         rd wr wdata        rsp          final
        vt[0]  = '{3'b001, 12'h305, 32'h100,      5'd0, 1'b0, 1'b0, 32'h0,      1, 1, 32'h100,     32'h0,      32'h100};
        vt[1]  = '{3'b010, 12'h304, 32'h80,       5'd0, 1'b0, 1'b0, 32'h8,      1, 1, 32'h88,      32'h8,      32'h88};
        vt[2]  = '{3'b011, 12'h304, 32'h0,        5'd0, 1'b0, 1'b1, 32'h88,     1, 0, 32'h0,       32'h88,     32'h88};
        vt[3]  = '{3'b101, 12'h341, 32'hFFFF,     5'd5, 1'b1, 1'b0, 32'h1234,   0, 1, 32'h5,       32'h0,      32'h5};
        vt[4]  = '{3'b011, 12'h304, 32'h0F,       5'd0, 1'b0, 1'b0, 32'hFF,     1, 1, 32'hF0,      32'hFF,     32'hF0};
        vt[5]  = '{3'b110, 12'h342, 32'hFFFFFFFF, 5'd3, 1'b0, 1'b0, 32'h10,     1, 1, 32'h13,      32'h10,     32'h13};
        vt[6]  = '{3'b111, 12'h344, 32'h0,        5'd1, 1'b0, 1'b0, 32'hF,      1, 1, 32'hE,       32'hF,      32'hE};
        vt[7]  = '{3'b000, 12'h300, 32'h1,        5'd0, 1'b0, 1'b0, 32'h55,     0, 0, 32'h0,       32'h0,      32'h55};
        vt[8]  = '{3'b001, 12'h7C0, 32'hAA,       5'd0, 1'b0, 1'b0, 32'h0,      1, 1, 32'hAA,      32'h0,      32'h0};
        vt[9]  = '{3'b001, 12'h305, 32'h99,       5'd0, 1'b1, 1'b0, 32'h77,     0, 1, 32'h99,      32'h0,      32'h99};
        vt[10] = '{3'b010, 12'h300, 32'h0,        5'd0, 1'b1, 1'b1, 32'h1888,   1, 0, 32'h0,       32'h1888,   32'h1888};
        vt[11] = '{3'b100, 12'h304, 32'h0,        5'd7, 1'b0, 1'b0, 32'h3,      0, 0, 32'h0,       32'h0,      32'h3};

        // Outputs while held in reset.
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, bus.req_ready}, 32'h1);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_strobes", {30'b0, bus.csr_reg_rdpin, bus.csr_reg_wrpin}, 32'h0);
        chk("rst_pulses", {29'b0, bus.rsp_valid, bus.redirect_valid, bus.evt_ack}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            preload(vt[i].addr, vt[i].init);
            bus.req_valid = 1'b1; bus.req_op = vt[i].op; bus.req_addr = vt[i].addr;
            bus.req_rs1 = vt[i].rs1; bus.req_zimm = vt[i].zimm;
            bus.req_rd_zero = vt[i].rd_zero; bus.req_src_zero = vt[i].src_zero;
            #1 chk($sformatf("v%0d_ready", i), {31'b0, bus.req_ready}, 32'h1);
            @(negedge clk);
            bus.req_valid = 1'b0; bus.req_op = 3'b001; bus.req_rs1 = 32'hDEADBEEF;
            bus.req_zimm = 5'h1F; bus.req_rd_zero = ~vt[i].rd_zero; bus.req_src_zero = ~vt[i].src_zero;
            chk($sformatf("v%0d_c1_rdpin", i), {31'b0, bus.csr_reg_rdpin}, {31'b0, vt[i].exp_rd});
            chk($sformatf("v%0d_c1_addr", i), bus.csr_addr32, {20'b0, vt[i].addr});
            chk($sformatf("v%0d_c1_ready", i), {30'b0, bus.req_ready, bus.busy}, 32'h1);
            @(negedge clk);
            chk($sformatf("v%0d_c2_strobes", i), {30'b0, bus.csr_reg_rdpin, bus.csr_reg_wrpin},
                {31'b0, vt[i].exp_wr});
            if (vt[i].exp_wr) chk($sformatf("v%0d_c2_wdata", i), bus.csr_wdata, vt[i].exp_wdata);
            @(negedge clk);
            chk($sformatf("v%0d_c3_rsp_valid", i), {31'b0, bus.rsp_valid}, 32'h1);
            chk($sformatf("v%0d_c3_rsp_rdata", i), bus.rsp_rdata, vt[i].exp_rsp);
            chk($sformatf("v%0d_c3_ready", i), {31'b0, bus.req_ready}, 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d_c4_idle", i), {29'b0, bus.rsp_valid, bus.busy, bus.req_ready}, 32'h1);
            chk($sformatf("v%0d_final", i), csr_val(vt[i].addr), vt[i].exp_final);
        end

        // Trap with a simultaneous instruction request: trap wins.
        preload(12'h300, 32'h8);
        preload(12'h305, 32'h1001);
        preload(12'h304, 32'h0);
        bus.trap_req = 1'b1; bus.trap_pc = 32'h200; bus.trap_cause = 32'h8000_0007;
        bus.req_valid = 1'b1; bus.req_op = 3'b001; bus.req_addr = 12'h304; bus.req_rs1 = 32'h5A;
        #1 chk("trap_evt_ack", {31'b0, bus.evt_ack}, 32'h1);
        chk("trap_req_ready", {31'b0, bus.req_ready}, 32'h0);
        @(negedge clk);
        bus.trap_req = 1'b0; bus.req_valid = 1'b0; bus.trap_pc = 32'hFFFF; bus.trap_cause = 32'h0;
        chk("trap_csr_pc", bus.csr_pc, 32'h200);
        chk("trap_c1_wdata", bus.csr_wdata, 32'h200);
        watch_redirect(cyc, rpc, clash, rsps);
        chk("trap_redirect_cycle", cyc, 6);
`ifdef CSR_VECTORED_EN
        chk("trap_redirect_pc", rpc, 32'h101C);
`else
        chk("trap_redirect_pc", rpc, 32'h1000);
`endif
        chk("trap_strobe_clash", clash, 0);
        chk("trap_no_rsp", rsps, 0);
        chk("trap_mepc", csr_val(12'h341), 32'h200);
        chk("trap_mcause", csr_val(12'h342), 32'h8000_0007);
        chk("trap_mstatus", csr_val(12'h300), 32'h1880);
        chk("trap_mie_untouched", csr_val(12'h304), 32'h0);

        // MRET.
        preload(12'h341, 32'h203);
        bus.mret_req = 1'b1;
        #1 chk("mret_evt_ack", {31'b0, bus.evt_ack}, 32'h1);
        chk("mret_req_ready", {31'b0, bus.req_ready}, 32'h0);
        @(negedge clk);
        bus.mret_req = 1'b0;
        watch_redirect(cyc, rpc, clash, rsps);
        chk("mret_redirect_cycle", cyc, 4);
        chk("mret_redirect_pc", rpc, 32'h200);
        chk("mret_strobe_clash", clash, 0);
        chk("mret_mstatus", csr_val(12'h300), 32'h1888);

        // MRET raised while an instruction is in flight waits for IDLE.
        bus.req_valid = 1'b1; bus.req_op = 3'b010; bus.req_addr = 12'h304;
        bus.req_rs1 = 32'h0; bus.req_src_zero = 1'b1; bus.req_rd_zero = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.mret_req = 1'b1;
        #1 chk("pend_c1_ack", {31'b0, bus.evt_ack}, 32'h0);
        @(negedge clk);
        chk("pend_c2_ack", {31'b0, bus.evt_ack}, 32'h0);
        @(negedge clk);
        chk("pend_c3_ack_rsp", {30'b0, bus.evt_ack, bus.rsp_valid}, 32'h1);
        @(negedge clk);
        chk("pend_c4_ack", {31'b0, bus.evt_ack}, 32'h1);
        @(negedge clk);
        bus.mret_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("pend_idle", {31'b0, bus.busy}, 32'h0);

        // Reset asserted during T_SRD.
        bus.trap_req = 1'b1; bus.trap_pc = 32'h300; bus.trap_cause = 32'h3;
        @(negedge clk);
        bus.trap_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmid_tsrd_read", {bus.csr_reg_rdpin, bus.csr_addr32[30:0]}, 32'h8000_0300);
        rst = 1'b0;
        #1 chk("rmid_strobes", {30'b0, bus.csr_reg_rdpin, bus.csr_reg_wrpin}, 32'h0);
        chk("rmid_addr", bus.csr_addr32, 32'h0);
        chk("rmid_wdata", bus.csr_wdata, 32'h0);
        chk("rmid_csr_pc", bus.csr_pc, 32'h0);
        chk("rmid_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rmid_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rmid_flags", {28'b0, bus.busy, bus.rsp_valid, bus.redirect_valid, bus.evt_ack}, 32'h0);
        chk("rmid_ready", {31'b0, bus.req_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        watch_redirect(cyc, rpc, clash, rsps);
        chk("rmid_no_redirect", cyc, 0);
        chk("rmid_mepc_kept", csr_val(12'h341), 32'h300);
        chk("rmid_mstatus_kept", csr_val(12'h300), 32'h1888);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
